csr_access_ctrl: RTL
====================

Name: csr_access_ctrl

Overview:
- Sequences all accesses to the 4096x32 machine CSR array (one combinational read port, one synchronous write port).
- Arbitrates between pipeline CSR instructions (CSRRW/RS/RC and immediate forms), trap entry and MRET.
- Performs read-modify-write as a multi-cycle FSM.
- Produces the PC redirect for trap entry and return.

Parameters:
- XLEN, 32, CSR data width
- MTVEC_ADDR, 12'h305, trap vector CSR
- MSTATUS_ADDR, 12'h300, status CSR (MIE bit 3, MPIE bit 7)
- MEPC_ADDR, 12'h341, exception PC CSR
- MCAUSE_ADDR, 12'h342, cause CSR
- MTVAL_ADDR, 12'h343, trap value CSR

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- req_valid  in  1  CSR instruction request
- req_ready  out  1  request accepted this cycle
- req_op  in  3  funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- req_addr  in  12  CSR address
- req_src  in  XLEN  rs1 value or zero-extended uimm
- req_src_nz  in  1  rs1 index / uimm nonzero
- rsp_valid  out  1  one-cycle pulse, old CSR value on rsp_rdata
- rsp_rdata  out  XLEN  old CSR value
- rsp_illegal  out  1  qualifies rsp_valid; access illegal, no write performed
- trap_valid  in  1  trap entry request
- trap_ready  out  1  trap accepted
- trap_pc, trap_cause, trap_tval  in  XLEN each  trap information
- mret_valid  in  1  MRET request (accepted with trap_ready)
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  XLEN  new fetch PC
- csr_rd  out  1  CSR array read enable
- csr_wr  out  1  CSR array write enable
- rd_addr, wr_addr  out  12 each  CSR array addresses
- rd_dat  in  XLEN  CSR array read data (combinational)
- wr_dat  out  XLEN  CSR array write data

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0, except req_ready=1 and trap_ready=1.
  - Internal capture registers cleared.
- Arbitration in IDLE:
  - Priority is trap_valid > mret_valid > req_valid.
  - trap_ready=req_ready=1 only in IDLE.
  - A lower-priority request not taken must be held by its source.
- CSR instruction path:
  - IDLE -> RMW_RD: drive csr_rd=1, rd_addr=req_addr, and capture rd_dat into old.
  - RMW_RD -> RMW_WR: compute new.
    - RW: new=src.
    - RS: new=old|src.
    - RC: new=old&~src.
  - RMW_WR: csr_wr=1, wr_addr=addr, wr_dat=new.
    - The write is suppressed when the op is RS/RC/RSI/RCI and src_nz=0.
    - Same cycle: rsp_valid=1, rsp_rdata=old. Then -> IDLE.
  - Latency is 3 cycles from acceptance to rsp_valid.
  - Reserved funct3 (000, 100): skip the write, rsp_valid with rsp_illegal=1 and rsp_rdata=0.
- Trap path:
  - The states below run in order, one cycle each. Then -> IDLE.

    | State   | Action |
    |---------|--------|
    | T_EPC   | Write mepc = trap_pc & ~3. |
    | T_CAUSE | Write mcause. |
    | T_TVAL  | Write mtval. |
    | T_STS   | Read mstatus; write new value with MPIE = old MIE, MIE = 0 (combinational read and write in the same cycle). |
    | T_VEC   | Read mtvec; redirect_valid=1, redirect_pc = mtvec & ~3. |

  - Trap inputs are captured at acceptance.
- MRET path:
  - M_STS: read mstatus; write MIE = MPIE, MPIE = 1.
  - M_EPC: read mepc; redirect_valid=1, redirect_pc = mepc.
  - Then -> IDLE.
- Reads and writes in the same cycle to the same address: the read returns the pre-write value (the array writes at the clock edge).
- Reset mid-sequence aborts immediately. Partial CSR writes already performed remain.
- Requests arriving while the FSM is busy are ignored (ready=0). Simultaneous trap and req: the trap wins and req_ready stays 0.

Optional Feature:
- Macro: CSR_RO_CHECK_EN.
- Defined: a CSR instruction whose write would not be suppressed, to an address with addr[11:10]==2'b11 (read-only space):
  - No write.
  - rsp_valid with rsp_illegal=1 and rsp_rdata=old.
  - Latency unchanged.
- Undefined: no read-only checks. Writes proceed and rsp_illegal is asserted only for reserved funct3.

Decomposition:
- Package csr_pkg holds:
  - The CSR address constants.
  - The mstatus bit positions MIE_BIT=3 and MPIE_BIT=7.
  - The funct3 op enum csr_op_e.
  - The FSM state enum csr_state_e.
- One sub-module csr_alu (combinational): inputs op, old, src, src_nz; outputs new value, write-enable and illegal flag.

Test Plan:
- CSRRW addr 0x340, src=0xDEADBEEF, prior 0x12345678:
  - rsp_valid 3 cycles after acceptance, rsp_rdata=0x12345678.
  - Array holds 0xDEADBEEF.
- CSRRS 0x340, src=0x0F, src_nz=0, prior 0xF0: rsp_rdata=0xF0, no csr_wr pulse. Repeat with src_nz=1: the array becomes 0xFF.
- Trap with pc=0x80000102, cause=0x2, tval=0x13, mtvec=0x80000041, mstatus=0x8:
  - mepc=0x80000100, mcause=2, mtval=0x13, mstatus=0x80.
  - redirect_pc=0x80000040 on the 5th cycle.
- MRET with mepc=0x80000200, mstatus=0x80: mstatus=0x88, redirect_pc=0x80000200.
- trap_valid and req_valid high together: trap_ready=1 and req_ready=0. The req is accepted in the cycle after the redirect. Reset asserted during T_CAUSE forces IDLE immediately with all outputs at reset values.
- With CSR_RO_CHECK_EN, CSRRW to 0xF14: rsp_illegal=1 and no csr_wr. CSRRS with src_nz=0 to 0xF14: legal read.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine CSR access controller:
// CSR addresses, mstatus bit positions, funct3 encodings and FSM states.
package csr_pkg;

  localparam int CSR_XLEN = 32;

  localparam logic [11:0] MSTATUS_ADDR = 12'h300;
  localparam logic [11:0] MTVEC_ADDR   = 12'h305;
  localparam logic [11:0] MEPC_ADDR    = 12'h341;
  localparam logic [11:0] MCAUSE_ADDR  = 12'h342;
  localparam logic [11:0] MTVAL_ADDR   = 12'h343;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  // funct3 encodings; 3'b000 and 3'b100 are reserved and decode as illegal
  typedef enum logic [2:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RMW_RD  = 4'd1,
    ST_RMW_EX  = 4'd2,
    ST_RMW_WR  = 4'd3,
    ST_T_EPC   = 4'd4,
    ST_T_CAUSE = 4'd5,
    ST_T_TVAL  = 4'd6,
    ST_T_STS   = 4'd7,
    ST_T_VEC   = 4'd8,
    ST_M_STS   = 4'd9,
    ST_M_EPC   = 4'd10
  } csr_state_e;

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Bus bundle between the pipeline/CSR array side (master) and the
// CSR access controller (slave).
interface csr_access_ctrl_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_src;
  logic            req_src_nz;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;

  logic            trap_valid;
  logic            trap_ready;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_tval;
  logic            mret_valid;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            csr_rd;
  logic            csr_wr;
  logic [11:0]     rd_addr;
  logic [11:0]     wr_addr;
  logic [XLEN-1:0] rd_dat;
  logic [XLEN-1:0] wr_dat;

  modport master (
    output req_valid, req_op, req_addr, req_src, req_src_nz,
    output trap_valid, trap_pc, trap_cause, trap_tval, mret_valid,
    output rd_dat,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal,
    input  trap_ready, redirect_valid, redirect_pc,
    input  csr_rd, csr_wr, rd_addr, wr_addr, wr_dat
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_src, req_src_nz,
    input  trap_valid, trap_pc, trap_cause, trap_tval, mret_valid,
    input  rd_dat,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal,
    output trap_ready, redirect_valid, redirect_pc,
    output csr_rd, csr_wr, rd_addr, wr_addr, wr_dat
  );

endinterface

// File: rtl/csr_alu.sv
// Combinational read-modify-write datapath for CSR instructions:
// new value, write enable (set/clear with zero source never write) and reserved-op flag.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = CSR_XLEN
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  input  logic            src_nz,
  output logic [XLEN-1:0] new_val,
  output logic            wr_en,
  output logic            illegal
);

  always_comb begin
    new_val = '0;
    wr_en   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RW, OP_RWI: begin
        new_val = src;
        wr_en   = 1'b1;
      end
      OP_RS, OP_RSI: begin
        new_val = old_val | src;
        wr_en   = src_nz;
      end
      OP_RC, OP_RCI: begin
        new_val = old_val & ~src;
        wr_en   = src_nz;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequencer for the machine CSR array: CSR instruction RMW, trap entry and MRET.
// Optional CSR_RO_CHECK_EN: writes into addr[11:10]==2'b11 are rejected as illegal.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN = CSR_XLEN
) (
  input  logic               clk,
  input  logic               reset,
  csr_access_ctrl_if.slave   bus
);

  csr_state_e      state_reg, state_next;

  logic [2:0]      op_reg;
  logic [11:0]     addr_reg;
  logic [XLEN-1:0] src_reg;
  logic            src_nz_reg;
  logic [XLEN-1:0] old_reg;
  logic [XLEN-1:0] new_reg;
  logic [XLEN-1:0] rdata_reg;
  logic            we_reg;
  logic            ill_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] cause_reg;
  logic [XLEN-1:0] tval_reg;

  logic [XLEN-1:0] alu_new;
  logic            alu_we;
  logic            alu_ill;
  logic            ro_hit;
  logic [XLEN-1:0] sts_val;

  logic idle, take_trap, take_mret, take_req;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op      (op_reg),
    .old_val (old_reg),
    .src     (src_reg),
    .src_nz  (src_nz_reg),
    .new_val (alu_new),
    .wr_en   (alu_we),
    .illegal (alu_ill)
  );

`ifdef CSR_RO_CHECK_EN
  assign ro_hit = alu_we && (addr_reg[11:10] == 2'b11);
`else
  assign ro_hit = 1'b0;
`endif

  // Fixed priority: trap, then MRET, then CSR instruction
  assign idle      = (state_reg == ST_IDLE);
  assign take_trap = idle && bus.trap_valid;
  assign take_mret = idle && !bus.trap_valid && bus.mret_valid;
  assign take_req  = idle && !bus.trap_valid && !bus.mret_valid && bus.req_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (take_trap)      state_next = ST_T_EPC;
        else if (take_mret) state_next = ST_M_STS;
        else if (take_req)  state_next = ST_RMW_RD;
      end
      ST_RMW_RD:  state_next = ST_RMW_EX;
      ST_RMW_EX:  state_next = ST_RMW_WR;
      ST_RMW_WR:  state_next = ST_IDLE;
      ST_T_EPC:   state_next = ST_T_CAUSE;
      ST_T_CAUSE: state_next = ST_T_TVAL;
      ST_T_TVAL:  state_next = ST_T_STS;
      ST_T_STS:   state_next = ST_T_VEC;
      ST_T_VEC:   state_next = ST_IDLE;
      ST_M_STS:   state_next = ST_M_EPC;
      ST_M_EPC:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      addr_reg   <= '0;
      src_reg    <= '0;
      src_nz_reg <= 1'b0;
      old_reg    <= '0;
      new_reg    <= '0;
      rdata_reg  <= '0;
      we_reg     <= 1'b0;
      ill_reg    <= 1'b0;
      pc_reg     <= '0;
      cause_reg  <= '0;
      tval_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (take_req) begin
        op_reg     <= bus.req_op;
        addr_reg   <= bus.req_addr;
        src_reg    <= bus.req_src;
        src_nz_reg <= bus.req_src_nz;
      end
      if (take_trap) begin
        pc_reg    <= bus.trap_pc;
        cause_reg <= bus.trap_cause;
        tval_reg  <= bus.trap_tval;
      end
      if (state_reg == ST_RMW_RD) old_reg <= bus.rd_dat;
      // Reserved ops return zero; read-only rejects still return the old value
      if (state_reg == ST_RMW_EX) begin
        new_reg   <= alu_new;
        we_reg    <= alu_we && !ro_hit;
        ill_reg   <= alu_ill || ro_hit;
        rdata_reg <= alu_ill ? '0 : old_reg;
      end
    end
  end

  always_comb begin
    bus.trap_ready     = idle;
    bus.req_ready      = idle && !bus.trap_valid && !bus.mret_valid;
    bus.rsp_valid      = 1'b0;
    bus.rsp_rdata      = '0;
    bus.rsp_illegal    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.csr_rd         = 1'b0;
    bus.csr_wr         = 1'b0;
    bus.rd_addr        = '0;
    bus.wr_addr        = '0;
    bus.wr_dat         = '0;
    sts_val            = bus.rd_dat;
    case (state_reg)
      ST_RMW_RD: begin
        bus.csr_rd  = 1'b1;
        bus.rd_addr = addr_reg;
      end
      ST_RMW_WR: begin
        bus.csr_wr      = we_reg;
        bus.wr_addr     = addr_reg;
        bus.wr_dat      = new_reg;
        bus.rsp_valid   = 1'b1;
        bus.rsp_rdata   = rdata_reg;
        bus.rsp_illegal = ill_reg;
      end
      ST_T_EPC: begin
        bus.csr_wr  = 1'b1;
        bus.wr_addr = MEPC_ADDR;
        bus.wr_dat  = {pc_reg[XLEN-1:2], 2'b00};
      end
      ST_T_CAUSE: begin
        bus.csr_wr  = 1'b1;
        bus.wr_addr = MCAUSE_ADDR;
        bus.wr_dat  = cause_reg;
      end
      ST_T_TVAL: begin
        bus.csr_wr  = 1'b1;
        bus.wr_addr = MTVAL_ADDR;
        bus.wr_dat  = tval_reg;
      end
      ST_T_STS: begin
        sts_val[MPIE_BIT] = bus.rd_dat[MIE_BIT];
        sts_val[MIE_BIT]  = 1'b0;
        bus.csr_rd  = 1'b1;
        bus.rd_addr = MSTATUS_ADDR;
        bus.csr_wr  = 1'b1;
        bus.wr_addr = MSTATUS_ADDR;
        bus.wr_dat  = sts_val;
      end
      ST_T_VEC: begin
        bus.csr_rd         = 1'b1;
        bus.rd_addr        = MTVEC_ADDR;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = {bus.rd_dat[XLEN-1:2], 2'b00};
      end
      ST_M_STS: begin
        sts_val[MIE_BIT]  = bus.rd_dat[MPIE_BIT];
        sts_val[MPIE_BIT] = 1'b1;
        bus.csr_rd  = 1'b1;
        bus.rd_addr = MSTATUS_ADDR;
        bus.csr_wr  = 1'b1;
        bus.wr_addr = MSTATUS_ADDR;
        bus.wr_dat  = sts_val;
      end
      ST_M_EPC: begin
        bus.csr_rd         = 1'b1;
        bus.rd_addr        = MEPC_ADDR;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.rd_dat;
      end
      default: ;
    endcase
  end

endmodule
